// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and index helper for the stream multiplexer
package stream_mux_pkg;

  // Selection modes of stream_mux_rr
  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Increment a channel index, wrapping to 0 after n-1
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational round-robin arbiter starting at a pointer
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [CW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  // Scan ptr, ptr+1, ... with wrap; the first requester seen wins
  always_comb begin
    int unsigned idx;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 32'(ptr);
    for (int k = 0; k < N_CH; k++) begin
      if (!gnt_valid && req[idx[CW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[CW-1:0];
      end
      idx = next_idx(idx, N_CH);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream multiplexer with registered output, select or round-robin
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH*WIDTH-1:0]      in_data,
  output logic [N_CH-1:0]            in_ready,
  input  logic [$clog2(N_CH)-1:0]    sel,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(N_CH)-1:0]    out_ch,
  input  logic                       out_ready
);

  localparam int CW = $clog2(N_CH);

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    win;
  logic             gvalid;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] ch_data [N_CH];
  logic [WIDTH-1:0] win_data;

  // Split the packed input bus into one word per channel
  for (genvar i = 0; i < N_CH; i++) begin : g_split
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  if (MODE == MODE_RR) begin : g_rr
    logic sel_unused;
    assign sel_unused = ^sel;

    rr_arbiter #(
      .N_CH (N_CH),
      .CW   (CW)
    ) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .gnt_idx   (win),
      .gnt_valid (gvalid)
    );
  end else begin : g_sel
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    // External select; an index beyond the last channel never grants
    always_comb begin
      win    = sel;
      gvalid = 1'b0;
      if (32'(sel) < N_CH) begin
        gvalid = in_valid[sel];
      end
    end
  end

  // The output register can take a beat when empty or being drained this cycle
  assign can_load = !out_valid || out_ready;
  assign xfer     = can_load && gvalid;
  assign win_data = ch_data[win];

  // Only the winning channel ever sees ready
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = xfer && (32'(win) == i);
    end
  end

  // Output stage and rotation pointer; the pointer only moves on a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_ch    <= win;
      if (MODE == MODE_RR) begin
        ptr <= CW'(next_idx(32'(win), N_CH));
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr in round-robin and select modes
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance a: 4 channels, round-robin
  logic [3:0]  a_valid;
  logic [31:0] a_data;
  logic [3:0]  a_ready;
  logic [1:0]  a_sel;
  logic        a_ovalid;
  logic [7:0]  a_odata;
  logic [1:0]  a_och;
  logic        a_oready;
  logic [7:0]  a_cur [4];

  // Instance b: 3 channels, round-robin
  logic [2:0]  b_valid;
  logic [23:0] b_data;
  logic [2:0]  b_ready;
  logic [1:0]  b_sel;
  logic        b_ovalid;
  logic [7:0]  b_odata;
  logic [1:0]  b_och;
  logic        b_oready;
  logic [7:0]  b_cur [3];

  // Instance c: 4 channels, external select
  logic [3:0]  c_valid;
  logic [31:0] c_data;
  logic [3:0]  c_ready;
  logic [1:0]  c_sel;
  logic        c_ovalid;
  logic [7:0]  c_odata;
  logic [1:0]  c_och;
  logic        c_oready;
  logic [7:0]  c_cur [4];

  assign a_data = {a_cur[3], a_cur[2], a_cur[1], a_cur[0]};
  assign b_data = {b_cur[2], b_cur[1], b_cur[0]};
  assign c_data = {c_cur[3], c_cur[2], c_cur[1], c_cur[0]};

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .sel(a_sel), .out_valid(a_ovalid), .out_data(a_odata), .out_ch(a_och), .out_ready(a_oready)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .sel(b_sel), .out_valid(b_ovalid), .out_data(b_odata), .out_ch(b_och), .out_ready(b_oready)
  );

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .sel(c_sel), .out_valid(c_ovalid), .out_data(c_odata), .out_ch(c_och), .out_ready(c_oready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] sb [$];
  logic [9:0] exp_beat;
  int         wait_cnt [4];
  int         max_wait;
  int         g_last;
  int         n_beats;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic monitor_a();
    int g;
    g = -1;
    if (a_ovalid && a_oready) begin
      if (sb.size() == 0) begin
        check("sb_extra_beat", 32'(a_och), 32'hFFFF);
      end else begin
        exp_beat = sb.pop_front();
        check("sb_beat", {22'd0, a_och, a_odata}, {22'd0, exp_beat});
        n_beats++;
      end
    end
    check("rand_ready_onehot", 32'($countones(a_ready) <= 1), 32'd1);
    check("rand_ready_valid", 32'(a_ready & ~a_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (a_valid[i] && a_ready[i]) begin
        sb.push_back({2'(i), a_cur[i]});
        g = i;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!a_valid[i] || i == g) begin
        wait_cnt[i] = 0;
      end else if (g >= 0) begin
        wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    g_last = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    a_valid  = '0; a_sel = '0; a_oready = 1'b0;
    b_valid  = '0; b_sel = '0; b_oready = 1'b0;
    c_valid  = '0; c_sel = '0; c_oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_cur[i] = 8'h10 + 8'(i);
      c_cur[i] = 8'h20 + 8'(i);
    end
    for (int i = 0; i < 3; i++) b_cur[i] = 8'hB0 + 8'(i);

    // Reset state
    @(negedge clk);
    check("reset_out_valid", 32'(a_ovalid), 32'd0);
    check("reset_out_data", 32'(a_odata), 32'd0);
    check("reset_out_ch", 32'(a_och), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fairness: all channels valid, downstream always ready
    a_valid  = 4'hF;
    a_oready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j < 8) check("rr_fair_ready", 32'(a_ready), 32'd1 << (j % 4));
      if (j > 0) begin
        check("rr_fair_valid", 32'(a_ovalid), 32'd1);
        check("rr_fair_ch", 32'(a_och), 32'((j - 1) % 4));
        check("rr_fair_data", 32'(a_odata), 32'h10 + 32'((j - 1) % 4));
      end
    end
    @(posedge clk);
    #1;
    a_valid = '0;
    do_reset();

    // Backpressure: one beat held while downstream stalls
    a_cur[0] = 8'hA5;
    a_cur[1] = 8'h5A;
    a_valid  = 4'b0001;
    a_oready = 1'b0;
    @(posedge clk);
    #1;
    a_valid = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 32'(a_ovalid), 32'd1);
      check("bp_data", 32'(a_odata), 32'hA5);
      check("bp_ready", 32'(a_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    a_oready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(a_ready), 32'b0010);
    @(negedge clk);
    check("bp_next_ch", 32'(a_och), 32'd1);
    check("bp_next_data", 32'(a_odata), 32'h5A);

    // Asynchronous reset in the middle of a stalled beat
    @(posedge clk);
    #1;
    a_oready = 1'b0;
    a_valid  = '0;
    @(negedge clk);
    check("stall_before_reset", 32'(a_ovalid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(a_ovalid), 32'd0);
    check("async_rst_data", 32'(a_odata), 32'd0);
    check("async_rst_ch", 32'(a_och), 32'd0);
    rst = 1'b0;
    a_oready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("no_reemit", 32'(a_ovalid), 32'd0);
    end

    // Round-robin skip and wrap with three channels
    @(posedge clk);
    #1;
    b_oready = 1'b1;
    b_valid  = 3'b010;
    @(negedge clk);
    check("rr3_ready_ch1", 32'(b_ready), 32'b010);
    @(posedge clk);
    #1;
    b_valid = 3'b001;
    @(negedge clk);
    check("rr3_wrap_ready", 32'(b_ready), 32'b001);
    @(posedge clk);
    #1;
    b_valid = 3'b110;
    @(negedge clk);
    check("rr3_ptr1_ready", 32'(b_ready), 32'b010);
    check("rr3_wrap_ch", 32'(b_och), 32'd0);
    check("rr3_wrap_data", 32'(b_odata), 32'hB0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rr3_ptr2_ready", 32'(b_ready), 32'b100);
    check("rr3_ch1", 32'(b_och), 32'd1);
    @(posedge clk);
    #1;
    b_valid = '0;
    @(negedge clk);
    check("rr3_ch2", 32'(b_och), 32'd2);

    // External select mode
    @(posedge clk);
    #1;
    c_cur[2] = 8'h3C;
    c_sel    = 2'd2;
    c_valid  = 4'b0100;
    c_oready = 1'b1;
    @(negedge clk);
    check("sel_ready", 32'(c_ready), 32'b0100);
    @(posedge clk);
    #1;
    c_valid = 4'b0011;
    @(negedge clk);
    check("sel_out_valid", 32'(c_ovalid), 32'd1);
    check("sel_out_data", 32'(c_odata), 32'h3C);
    check("sel_out_ch", 32'(c_och), 32'd2);
    check("sel_no_ready", 32'(c_ready), 32'd0);
    @(negedge clk);
    check("sel_no_transfer", 32'(c_ovalid), 32'd0);

    // Constrained-random traffic against the scoreboard
    @(posedge clk);
    #1;
    a_valid  = '0;
    a_oready = 1'b0;
    do_reset();
    sb.delete();
    max_wait = 0;
    g_last   = -1;
    n_beats  = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      if (g_last >= 0) a_cur[g_last] = 8'($urandom);
      for (int i = 0; i < 4; i++) a_valid[i] = ($urandom_range(0, 9) < 6);
      a_oready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      monitor_a();
      @(posedge clk);
      #1;
    end
    a_valid  = '0;
    a_oready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      monitor_a();
      @(posedge clk);
      #1;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("rr_max_wait_bound", 32'(max_wait <= 3), 32'd1);
    check("rand_beats_flowed", 32'(n_beats > 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
